// File: rtl/seq_bit_serializer_pkg.sv
// Shared definitions for the serializer and the downstream sequence detector.
package seq_pkg;

    localparam int SEQ_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register for gapless streaming.
//   state | meaning
//   IDLE  | no word in sr; a held word is moved into sr at the next edge
//   SHIFT | sr is driving w; en advances one bit per cycle
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             en,
    output logic             w,
    output logic             bit_valid,
    output logic             last_bit
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    seq_state_t       state;
    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr_shifted;

    assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            sr         <= '0;
            cnt        <= '0;
        end else begin
            // Accept and drain never coincide: accept needs hold empty, drain needs it full.
            if (load_valid && !hold_valid) begin
                hold       <= data_in;
                hold_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (hold_valid) begin
                        sr         <= hold;
                        hold_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (en) begin
                        if (cnt != CNT_LAST) begin
                            sr  <= sr_shifted;
                            cnt <= cnt + CW'(1);
                        end else if (hold_valid) begin
                            sr         <= hold;
                            hold_valid <= 1'b0;
                            cnt        <= '0;
                        end else begin
                            sr    <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign load_ready = ~hold_valid;
    assign bit_valid  = (state == SHIFT);
    assign last_bit   = (state == SHIFT) && (cnt == CNT_LAST);
    assign w          = bit_valid & (MSB_FIRST ? sr[WIDTH-1] : sr[0]);

endmodule

// File: doc/seq_bit_serializer.md
SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 Parameter: WIDTH, 8, number of bits per parallel word (2..32).
REQ-002 Parameter: MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: data_in  input  WIDTH  parallel word offered by the producer.
REQ-006 Port: load_valid  input  1  data_in is valid this cycle.
REQ-007 Port: load_ready  output  1  holding register empty; the word is accepted when load_valid && load_ready at the rising edge.
REQ-008 Port: en  input  1  bit-advance enable; 0 stalls the serial stream.
REQ-009 Port: w  output  1  serial data bit for the downstream sequence detector.
REQ-010 Port: bit_valid  output  1  w carries a payload bit this cycle.
REQ-011 Port: last_bit  output  1  w is the final bit of the current word.

Function
REQ-012 Storage SHALL be: one WIDTH-bit holding register with hold_valid flag, one WIDTH-bit shift register sr, and a bit counter cnt of ceil(log2(WIDTH)) bits.
REQ-013 FSM SHALL have two states: IDLE and SHIFT.
REQ-014 load_ready SHALL equal ~hold_valid, driven from a register only; there is no combinational path from any input.
REQ-015 On an accepted word, data_in SHALL be written to the holding register and hold_valid SHALL be set.
REQ-016 IDLE with hold_valid=1: next edge SHALL copy hold to sr, clear hold_valid, set cnt=0, and enter SHIFT, regardless of en.
REQ-017 IDLE with hold_valid=0: the block SHALL stay in IDLE.
REQ-018 Latency: a word accepted at edge N SHALL present its first bit on w with bit_valid=1 in the cycle after edge N+1, when the block was IDLE.
REQ-019 w SHALL equal sr[WIDTH-1] when MSB_FIRST=1, else sr[0].
REQ-020 bit_valid SHALL equal (state==SHIFT).
REQ-021 last_bit SHALL equal (state==SHIFT && cnt==WIDTH-1).
REQ-022 w SHALL be 0 whenever bit_valid=0.
REQ-023 SHIFT with en=1 and cnt<WIDTH-1: sr SHALL shift one position toward the output end (zero fill) and cnt SHALL increment.
REQ-024 SHIFT with en=1 and cnt==WIDTH-1 and hold_valid=1: the block SHALL reload sr from hold, clear hold_valid, set cnt=0, and stay in SHIFT (gapless back-to-back words).
REQ-025 SHIFT with en=1 and cnt==WIDTH-1 and hold_valid=0: the block SHALL enter IDLE.
REQ-026 SHIFT with en=0: sr, cnt, and state SHALL hold, and w, bit_valid, and last_bit SHALL stay unchanged.
REQ-027 The holding register SHALL still accept a word during a stall.
REQ-028 Simultaneous drain and offer: hold is drained at the same edge while load_ready=0, so the offered word SHALL NOT be accepted that cycle; it SHALL be accepted at the next edge if load_valid is still 1.
REQ-029 Producer SHALL hold data_in and load_valid stable until accepted; the block SHALL NOT drop or duplicate any accepted word.

Reset
REQ-030 reset=1 at an edge SHALL force: state=IDLE, hold_valid=0, sr=0, cnt=0.
REQ-031 Outputs during and after reset SHALL be: w=0, bit_valid=0, last_bit=0, load_ready=1.
REQ-032 Reset has priority over all other inputs, including load_valid and en.
REQ-033 Reset mid-word SHALL discard both the in-flight word and the held word, with no partial resumption.

Structure
REQ-034 The state enumeration (IDLE, SHIFT) and the WIDTH default SHALL live in the shared package seq_pkg, also used by the detector.
REQ-035 No sub-module is warranted; the holding register, shifter, counter, and FSM SHALL be in one module.

Verification
REQ-036 Single word: WIDTH=8, MSB_FIRST=1, en=1, accept 8'h92 -> w = 1,0,0,1,0,0,1,0 on 8 consecutive bit_valid cycles, last_bit on the 8th, then IDLE.
REQ-037 Back-to-back: accept 8'h92 then 8'h4B while shifting -> 16 consecutive bit_valid cycles with no gap; load_ready=0 from acceptance of 8'h4B until its reload.
REQ-038 Stall: en=0 for 3 cycles after the 3rd bit of 8'hA5 -> w and bit_valid are frozen, and the stream resumes with bit 4 when en=1; total of 8 bits.
REQ-039 Backpressure: offer 3 words with load_valid held high -> the 3rd word is accepted only after the 2nd word moves into sr; no word is lost, and the output order is 1, 2, 3.
REQ-040 Reset mid-word: reset=1 after the 4th bit of 8'hFF with a held word pending -> the next cycle shows bit_valid=0 and load_ready=1; no bits from either word appear afterwards.
REQ-041 LSB-first and end-to-end: MSB_FIRST=0, word 8'h49 -> w = 1,0,0,1,0,0,1,0; a downstream 10010 detector fires on the 5th and 8th bits (overlapping matches).
